// File: rtl/alu_mul_seq_if.sv
// Bus bundle between the shift-and-add multiplier sequencer and its user.
// It carries the start/ready/done handshake, the kill input and the
// shared-ALU request/grant/operand/result path.
interface alu_mul_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             kill;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             alu_req;
  logic             alu_gnt;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_op1;
  logic [WIDTH-1:0] alu_op2;
  logic [WIDTH-1:0] alu_result;

  // Requester / ALU-arbiter side.
  modport master (
    output start, op_a, op_b, kill, alu_gnt, alu_result,
    input  ready, done, result, alu_req, alu_ctrl, alu_op1, alu_op2
  );

  // Multiplier sequencer side.
  modport slave (
    input  start, op_a, op_b, kill, alu_gnt, alu_result,
    output ready, done, result, alu_req, alu_ctrl, alu_op1, alu_op2
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Multi-cycle shift-and-add multiplier that borrows the execute-stage ALU
// adder.
// - Each granted RUN cycle adds mcand into acc through the ALU, but only when
//   the current multiplier bit is set.
// - It then shifts mcand left and mplier right.
// - The output is the low WIDTH bits of op_a*op_b.
module alu_mul_seq #(
  parameter int WIDTH      = 32,
  parameter int EARLY_EXIT = 0
) (
  input  logic         clk,
  input  logic         reset,
  alu_mul_seq_if.slave bus
);

  localparam int             CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt;

  logic accept;
  logic step;
  logic last_step;
  logic deliver;

  // A start is taken only in IDLE. A same-cycle kill drops it.
  assign accept    = (state == S_IDLE) && bus.start && !bus.kill;
  // The datapath advances only on a granted RUN cycle that is not being flushed.
  assign step      = (state == S_RUN) && bus.alu_gnt && !bus.kill;
  // This is the final iteration: either all WIDTH bits are consumed, or the
  // early-exit option is on and no set multiplier bits remain.
  assign last_step = (cnt == LAST_CNT) ||
                     ((EARLY_EXIT != 0) && ((mplier >> 1) == {WIDTH{1'b0}}));
  // DONE delivers a result unless it is flushed or reset in that same cycle.
  assign deliver   = (state == S_DONE) && !bus.kill && !reset;

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: IDLE -> RUN -> DONE -> IDLE. kill flushes back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.kill) begin
          state_nxt = S_IDLE;
        end else if (bus.alu_gnt && last_step) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Operand load, the shift-and-add iteration, and result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= {WIDTH{1'b0}};
      mcand    <= {WIDTH{1'b0}};
      mplier   <= {WIDTH{1'b0}};
      cnt      <= {CW{1'b0}};
      result_q <= {WIDTH{1'b0}};
    end else begin
      if (accept) begin
        acc    <= {WIDTH{1'b0}};
        mcand  <= bus.op_a;
        mplier <= bus.op_b;
        cnt    <= {CW{1'b0}};
      end else if (step) begin
        if (mplier[0]) begin
          acc <= bus.alu_result;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end
      if (deliver) begin
        result_q <= acc;
      end
    end
  end

  assign bus.ready    = (state == S_IDLE);
  assign bus.done     = deliver;
  // The product is shown straight from acc during DONE. That way result is
  // valid in the same cycle as done; afterwards the held register drives it.
  assign bus.result   = deliver ? acc : result_q;
  assign bus.alu_req  = (state == S_RUN);
  assign bus.alu_ctrl = 3'b000;
  assign bus.alu_op1  = acc;
  assign bus.alu_op2  = mcand;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq.
// - One instance runs with EARLY_EXIT=0 and one with EARLY_EXIT=1.
// - Each instance gets its own ALU adder model.
// - Expected products and latencies come from plain arithmetic on the operands
//   and on the grant pattern.
module tb_alu_mul_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  logic [W-1:0] model_result = '0;

  alu_mul_seq_if #(.WIDTH(W)) if0 ();
  alu_mul_seq_if #(.WIDTH(W)) if1 ();

  alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  alu_mul_seq #(.WIDTH(W), .EARLY_EXIT(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  // ALU adder seen by each sequencer.
  assign if0.alu_result = if0.alu_op1 + if0.alu_op2;
  assign if1.alu_result = if1.alu_op1 + if1.alu_op2;

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0];
  endfunction

  // Early-exit latency: one RUN cycle per significant multiplier bit (at least one), then DONE.
  function automatic int ref_early_lat(input logic [W-1:0] b);
    int len;
    len = 0;
    for (int i = 0; i < W; i++) if (b[i]) len = i + 1;
    if (len == 0) len = 1;
    return len + 1;
  endfunction

  // Drives one multiply on dut0 and gathers what it observed.
  // gmode: 0 = grant every cycle, 1 = grant low on odd RUN cycles, 2 = random grant.
  // poke: hold start high with junk operands while the operation is busy.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input int gmode, input bit poke,
                         output int cyc, output int misses, output logic [W-1:0] res_done,
                         output logic [W-1:0] res_after, output logic done_after,
                         output logic ready_after, output bit busy_ok);
    int grants;
    bit g;
    busy_ok = 1'b1; cyc = 0; misses = 0; grants = 0;
    if0.start = 1'b1; if0.op_a = a; if0.op_b = b; if0.kill = 1'b0; if0.alu_gnt = 1'b1;
    tick;
    if0.start = 1'b0;
    cyc = 1;
    while (if0.done !== 1'b1 && cyc < 300) begin
      case (gmode)
        0:       g = 1'b1;
        1:       g = (cyc % 2 == 0);
        default: g = 1'($urandom_range(0, 1));
      endcase
      if (grants < W) begin
        if (g) grants++;
        else   misses++;
      end
      if0.alu_gnt = g;
      if (poke && cyc >= 3) begin
        if0.start = 1'b1; if0.op_a = $urandom; if0.op_b = $urandom;
      end
      if (if0.alu_req !== 1'b1 || if0.ready !== 1'b0 || if0.alu_ctrl !== 3'b000) busy_ok = 1'b0;
      tick;
      cyc++;
    end
    res_done = if0.result;
    if0.alu_gnt = 1'b1;
    tick;
    done_after = if0.done; ready_after = if0.ready; res_after = if0.result;
    if0.start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    total++; if (if0.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", if0.ready); end
    total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b want=0", if0.done); end
    total++; if (if0.alu_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%0b want=0", if0.alu_req); end
    total++; if (if0.alu_ctrl !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%0b want=000", if0.alu_ctrl); end
    total++; if (if0.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%0h want=0", if0.result); end
    total++; if (if1.ready !== 1'b1) begin bad++; $display("FAIL reset_ready_ee got=%0b want=1", if1.ready); end
    reset = 1'b0;
    model_result = '0;
    tick;
  endtask

  task automatic test_basic;
    int cyc, misses; logic [W-1:0] rd, ra; logic da, ra_rdy; bit ok;
    run_mul(32'd7, 32'd6, 0, 1'b0, cyc, misses, rd, ra, da, ra_rdy, ok);
    total++; if (cyc !== 33) begin bad++; $display("FAIL basic_latency got=%0d want=33", cyc); end
    total++; if (rd !== 32'd42) begin bad++; $display("FAIL basic_result_at_done got=%0d want=42", rd); end
    total++; if (ra !== 32'd42) begin bad++; $display("FAIL basic_result_held got=%0d want=42", ra); end
    total++; if (da !== 1'b0) begin bad++; $display("FAIL basic_done_twice got=%0b want=0", da); end
    total++; if (ra_rdy !== 1'b1) begin bad++; $display("FAIL basic_ready_back got=%0b want=1", ra_rdy); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL basic_run_outputs got=%0b want=1", ok); end
    model_result = 32'd42;
  endtask

  task automatic test_wrap;
    int cyc, misses; logic [W-1:0] rd, ra; logic da, ra_rdy; bit ok;
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, cyc, misses, rd, ra, da, ra_rdy, ok);
    total++; if (rd !== 32'h0000_0001) begin bad++; $display("FAIL wrap_ff got=%0h want=1", rd); end
    total++; if (cyc !== 33) begin bad++; $display("FAIL wrap_ff_latency got=%0d want=33", cyc); end
    run_mul(32'h0001_0000, 32'h0001_0000, 0, 1'b0, cyc, misses, rd, ra, da, ra_rdy, ok);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL wrap_10000 got=%0h want=0", rd); end
    total++; if (ra !== 32'h0) begin bad++; $display("FAIL wrap_10000_held got=%0h want=0", ra); end
    model_result = 32'h0;
  endtask

  task automatic test_stall;
    int cyc, misses; logic [W-1:0] rd, ra; logic da, ra_rdy; bit ok;
    run_mul(32'd5, 32'd3, 1, 1'b0, cyc, misses, rd, ra, da, ra_rdy, ok);
    total++; if (cyc !== 65) begin bad++; $display("FAIL stall_latency got=%0d want=65", cyc); end
    total++; if (rd !== 32'd15) begin bad++; $display("FAIL stall_result got=%0d want=15", rd); end
    total++; if (ok !== 1'b1) begin bad++; $display("FAIL stall_req_held got=%0b want=1", ok); end
    model_result = 32'd15;
  endtask

  task automatic test_random;
    int cyc, misses; logic [W-1:0] rd, ra, a, b, exp; logic da, ra_rdy; bit ok;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom;
      if (i == 0) b = 32'h8000_0000;
      exp = ref_mul(a, b);
      run_mul(a, b, 2, 1'b0, cyc, misses, rd, ra, da, ra_rdy, ok);
      total++; if (rd !== exp) begin bad++; $display("FAIL rand_result[%0d] got=%0h want=%0h", i, rd, exp); end
      total++; if (cyc !== W + 1 + misses) begin bad++; $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, cyc, W + 1 + misses); end
      total++; if (da !== 1'b0 || ra !== exp) begin bad++; $display("FAIL rand_after[%0d] got=%0b/%0h want=0/%0h", i, da, ra, exp); end
      model_result = exp;
    end
  endtask

  task automatic test_busy_start;
    int cyc, misses; logic [W-1:0] rd, ra, exp; logic da, ra_rdy; bit ok;
    exp = ref_mul(32'd1234, 32'd5678);
    run_mul(32'd1234, 32'd5678, 0, 1'b1, cyc, misses, rd, ra, da, ra_rdy, ok);
    total++; if (rd !== exp) begin bad++; $display("FAIL busy_result got=%0h want=%0h", rd, exp); end
    total++; if (cyc !== 33) begin bad++; $display("FAIL busy_latency got=%0d want=33", cyc); end
    total++; if (ra_rdy !== 1'b1) begin bad++; $display("FAIL busy_start_in_done got=%0b want=1", ra_rdy); end
    model_result = exp;
  endtask

  task automatic test_kill;
    int cyc, misses; logic [W-1:0] rd, ra; logic da, ra_rdy; bit ok, seen;
    if0.op_a = 32'd123; if0.op_b = 32'd45; if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    repeat (9) tick;
    if0.kill = 1'b1;
    tick;
    if0.kill = 1'b0;
    total++; if (if0.ready !== 1'b1) begin bad++; $display("FAIL kill_run_idle got=%0b want=1", if0.ready); end
    total++; if (if0.result !== model_result) begin bad++; $display("FAIL kill_run_result got=%0h want=%0h", if0.result, model_result); end
    seen = 1'b0;
    repeat (40) begin tick; if (if0.done === 1'b1) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL kill_run_no_done got=%0b want=0", seen); end
    // A start that arrives together with kill is dropped.
    if0.start = 1'b1; if0.kill = 1'b1;
    tick;
    if0.start = 1'b0; if0.kill = 1'b0;
    total++; if (if0.ready !== 1'b1) begin bad++; $display("FAIL kill_start_drop got=%0b want=1", if0.ready); end
    // A kill that lands on the DONE cycle suppresses done and keeps the old result.
    if0.op_a = 32'd11; if0.op_b = 32'd13; if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    repeat (32) tick;
    if0.kill = 1'b1;
    #1;
    total++; if (if0.done !== 1'b0) begin bad++; $display("FAIL kill_done_suppressed got=%0b want=0", if0.done); end
    tick;
    if0.kill = 1'b0;
    total++; if (if0.ready !== 1'b1 || if0.result !== model_result) begin bad++; $display("FAIL kill_done_result got=%0b/%0h want=1/%0h", if0.ready, if0.result, model_result); end
    run_mul(32'd3, 32'd4, 0, 1'b0, cyc, misses, rd, ra, da, ra_rdy, ok);
    total++; if (rd !== 32'd12 || cyc !== 33) begin bad++; $display("FAIL kill_restart got=%0d/%0d want=12/33", rd, cyc); end
    model_result = 32'd12;
  endtask

  task automatic test_reset_mid;
    int cyc, misses; logic [W-1:0] rd, ra; logic da, ra_rdy; bit ok;
    if0.op_a = 32'd99; if0.op_b = 32'd77; if0.start = 1'b1;
    tick;
    if0.start = 1'b0;
    repeat (12) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    total++; if (if0.ready !== 1'b1 || if0.alu_req !== 1'b0 || if0.done !== 1'b0) begin bad++; $display("FAIL rstmid_ctrl got=%0b%0b%0b want=100", if0.ready, if0.alu_req, if0.done); end
    total++; if (if0.result !== 32'h0 || if0.alu_op1 !== 32'h0) begin bad++; $display("FAIL rstmid_regs got=%0h/%0h want=0/0", if0.result, if0.alu_op1); end
    run_mul(32'd2, 32'd3, 0, 1'b0, cyc, misses, rd, ra, da, ra_rdy, ok);
    total++; if (rd !== 32'd6 || cyc !== 33) begin bad++; $display("FAIL rstmid_clean got=%0d/%0d want=6/33", rd, cyc); end
    model_result = 32'd6;
  endtask

  task automatic test_early_exit;
    logic [W-1:0] a, b, exp;
    int cyc, lat;
    for (int i = 0; i < 8; i++) begin
      case (i)
        0:       begin a = 32'd9; b = 32'd4; end
        1:       begin a = $urandom; b = 32'd0; end
        2:       begin a = $urandom; b = 32'h8000_0000; end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      exp = ref_mul(a, b);
      lat = ref_early_lat(b);
      if1.op_a = a; if1.op_b = b; if1.start = 1'b1;
      tick;
      if1.start = 1'b0;
      cyc = 1;
      while (if1.done !== 1'b1 && cyc < 100) begin tick; cyc++; end
      total++; if (cyc !== lat) begin bad++; $display("FAIL early_latency[%0d] got=%0d want=%0d", i, cyc, lat); end
      total++; if (if1.result !== exp) begin bad++; $display("FAIL early_result[%0d] got=%0h want=%0h", i, if1.result, exp); end
      tick;
      total++; if (if1.done !== 1'b0 || if1.ready !== 1'b1) begin bad++; $display("FAIL early_after[%0d] got=%0b%0b want=01", i, if1.done, if1.ready); end
    end
  endtask

  initial begin
    if0.start = 1'b0; if0.op_a = '0; if0.op_b = '0; if0.kill = 1'b0; if0.alu_gnt = 1'b1;
    if1.start = 1'b0; if1.op_a = '0; if1.op_b = '0; if1.kill = 1'b0; if1.alu_gnt = 1'b1;
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_random;
    test_busy_start;
    test_kill;
    test_reset_mid;
    test_early_exit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
